// File: rtl/copy_pkg.sv
// Shared definitions for the copy-engine arbiter: FSM encoding, default job
// timeout and the geometry of the 16x8 RAM write port.
package copy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } copy_state_e;

  localparam int TIMEOUT_DEFAULT = 64;
  localparam int RAM_AW          = 4;
  localparam int RAM_DW          = 8;

endpackage

// File: rtl/copy_rr_pick.sv
// Round-robin requester selection: one-hot pick of the first active request
// found after the last granted index, wrapping around.
module copy_rr_pick #(
  parameter int NREQ = 3,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   last,
  output logic [NREQ-1:0] pick
);

  logic          found;
  logic [PW-1:0] idx;

  // The last granted index is visited last, so it only wins when it is the
  // sole requester.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = PW'((32'(last) + i) % NREQ);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/copy_arbiter.sv
// Arbitrates NREQ requesters onto one shared copy engine, with a per-job
// timeout and gating of the engine's RAM writes to the owning job.
module copy_arbiter
  import copy_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   start_sig,
  output logic [NREQ-1:0]   done_sig,
  output logic [NREQ-1:0]   err_sig,
  output logic [NREQ-1:0]   grant,
  output logic              eng_start,
  input  logic              eng_done,
  input  logic              eng_write_en,
  input  logic [RAM_AW-1:0] eng_addr,
  input  logic [RAM_DW-1:0] eng_data,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [RAM_DW-1:0] ram_data
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  copy_state_e     state;
  logic [PW-1:0]   last_ptr;
  logic [PW-1:0]   pick_ptr;
  logic [NREQ-1:0] pick;
  logic [TW-1:0]   timer;

  copy_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req  (start_sig),
    .last (last_ptr),
    .pick (pick)
  );

  always_comb begin
    pick_ptr = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick[i]) pick_ptr = PW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      grant     <= '0;
      eng_start <= 1'b0;
      done_sig  <= '0;
      err_sig   <= '0;
      timer     <= '0;
      last_ptr  <= PW'(NREQ - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (|start_sig) begin
            grant     <= pick;
            last_ptr  <= pick_ptr;
            eng_start <= 1'b1;
            timer     <= '0;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // eng_done takes priority so a completion on the last allowed
          // cycle is never reported as a timeout.
          if (eng_done) begin
            eng_start <= 1'b0;
            done_sig  <= grant;
            state     <= ST_RELEASE;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            eng_start <= 1'b0;
            done_sig  <= grant;
            err_sig   <= grant;
            state     <= ST_RELEASE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_RELEASE: begin
          grant    <= '0;
          done_sig <= '0;
          err_sig  <= '0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ram_we   = eng_write_en & (state == ST_BUSY);
  assign ram_addr = eng_addr;
  assign ram_data = eng_data;

endmodule

// File: tb/tb_copy_arbiter.sv
// Directed testbench for copy_arbiter with NREQ=3, TIMEOUT=64.
module tb_copy_arbiter;

  logic       clk;
  logic       rst_n;
  logic [2:0] start_sig;
  logic [2:0] done_sig;
  logic [2:0] err_sig;
  logic [2:0] grant;
  logic       eng_start;
  logic       eng_done;
  logic       eng_write_en;
  logic [3:0] eng_addr;
  logic [7:0] eng_data;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_data;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned cnt;
  logic [2:0]  exp_g;

  copy_arbiter #(
    .NREQ    (3),
    .TIMEOUT (64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_sig    (start_sig),
    .done_sig     (done_sig),
    .err_sig      (err_sig),
    .grant        (grant),
    .eng_start    (eng_start),
    .eng_done     (eng_done),
    .eng_write_en (eng_write_en),
    .eng_addr     (eng_addr),
    .eng_data     (eng_data),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_data     (ram_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    rst_n        = 1'b0;
    start_sig    = 3'b000;
    eng_done     = 1'b0;
    eng_write_en = 1'b1;
    eng_addr     = 4'hA;
    eng_data     = 8'h5C;
    step();
    step();
    chk("rst_grant",     32'(grant),     32'h0);
    chk("rst_eng_start", 32'(eng_start), 32'h0);
    chk("rst_done",      32'(done_sig),  32'h0);
    chk("rst_err",       32'(err_sig),   32'h0);
    chk("rst_ram_we",    32'(ram_we),    32'h0);

    rst_n = 1'b1;
    step();
    chk("idle_ram_we",   32'(ram_we),   32'h0);
    chk("idle_ram_addr", 32'(ram_addr), 32'hA);
    chk("idle_ram_data", 32'(ram_data), 32'h5C);
    eng_write_en = 1'b0;

    // Fairness: all three request, each drops on its own done pulse.
    start_sig = 3'b111;
    step();
    exp_g = 3'b001;
    for (int k = 0; k < 3; k++) begin
      chk("fair_grant",     32'(grant),     32'(exp_g));
      chk("fair_eng_start", 32'(eng_start), 32'h1);
      repeat (3) step();
      eng_done = 1'b1;
      step();
      chk("fair_done",      32'(done_sig),  32'(exp_g));
      chk("fair_err",       32'(err_sig),   32'h0);
      chk("fair_eng_drop",  32'(eng_start), 32'h0);
      eng_done  = 1'b0;
      start_sig = start_sig & ~exp_g;
      step();
      chk("fair_dead_grant", 32'(grant),    32'h0);
      chk("fair_done_pulse", 32'(done_sig), 32'h0);
      step();
      exp_g = {exp_g[1:0], 1'b0};
    end
    chk("fair_idle_grant", 32'(grant), 32'h0);

    // eng_done with no job running has no effect.
    eng_done = 1'b1;
    step();
    step();
    chk("idle_done_ign",  32'(done_sig),  32'h0);
    chk("idle_grant_ign", 32'(grant),     32'h0);
    chk("idle_eng_ign",   32'(eng_start), 32'h0);
    eng_done = 1'b0;

    // Single request, requester drops early, engine answers 20 cycles in.
    start_sig = 3'b001;
    step();
    chk("single_grant",     32'(grant),     32'h1);
    chk("single_eng_start", 32'(eng_start), 32'h1);
    repeat (4) step();
    start_sig    = 3'b000;
    eng_write_en = 1'b1;
    #1;
    chk("busy_ram_we",   32'(ram_we),   32'h1);
    chk("busy_ram_addr", 32'(ram_addr), 32'hA);
    chk("busy_ram_data", 32'(ram_data), 32'h5C);
    eng_write_en = 1'b0;
    repeat (15) step();
    chk("single_still_busy", 32'(eng_start), 32'h1);
    eng_done = 1'b1;
    step();
    chk("single_done",     32'(done_sig),  32'h1);
    chk("single_err",      32'(err_sig),   32'h0);
    chk("single_eng_drop", 32'(eng_start), 32'h0);
    eng_done = 1'b0;
    step();
    chk("single_done_clr", 32'(done_sig), 32'h0);
    chk("single_grant_clr", 32'(grant),   32'h0);

    // Timeout: engine never answers.
    start_sig = 3'b001;
    step();
    chk("to_grant", 32'(grant), 32'h1);
    cnt = eng_start ? 1 : 0;
    for (int i = 0; i < 100 && eng_start; i++) begin
      step();
      if (eng_start) cnt++;
    end
    chk("to_eng_cycles", cnt,            32'd64);
    chk("to_done",       32'(done_sig),  32'h1);
    chk("to_err",        32'(err_sig),   32'h1);
    start_sig = 3'b000;
    step();
    chk("to_done_clr", 32'(done_sig), 32'h0);
    chk("to_err_clr",  32'(err_sig),  32'h0);
    chk("to_grant_clr", 32'(grant),   32'h0);

    // Collision: eng_done arrives in the 64th BUSY cycle.
    start_sig = 3'b010;
    step();
    chk("col_grant", 32'(grant), 32'h2);
    repeat (63) step();
    chk("col_still_busy", 32'(eng_start), 32'h1);
    eng_done = 1'b1;
    step();
    chk("col_done",     32'(done_sig),  32'h2);
    chk("col_err",      32'(err_sig),   32'h0);
    chk("col_eng_drop", 32'(eng_start), 32'h0);
    eng_done  = 1'b0;
    start_sig = 3'b000;
    step();

    // Reset at BUSY cycle 10.
    start_sig = 3'b100;
    step();
    chk("rmid_grant", 32'(grant), 32'h4);
    repeat (9) step();
    eng_write_en = 1'b1;
    #1;
    chk("rmid_ram_we_busy", 32'(ram_we), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rmid_eng_start", 32'(eng_start), 32'h0);
    chk("rmid_grant_clr", 32'(grant),     32'h0);
    chk("rmid_ram_we",    32'(ram_we),    32'h0);
    chk("rmid_done",      32'(done_sig),  32'h0);
    eng_write_en = 1'b0;
    step();
    rst_n     = 1'b1;
    start_sig = 3'b111;
    step();
    chk("rmid_first_grant", 32'(grant),     32'h1);
    chk("rmid_eng_restart", 32'(eng_start), 32'h1);
    start_sig = 3'b000;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
